// File: rtl/clock_set_controller.sv
// Time-of-day controller: 1 Hz prescaler, hh:mm:ss counters and the
// button-driven set-mode state machine, all on the single clk_100MHz domain.
module clock_set_controller #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       tick_1hz
);

  localparam int unsigned TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t        state;
  logic [TW-1:0] presc;
  logic [BW-1:0] blink_cnt;

  logic mode_s1, mode_s2, mode_s3;
  logic inc_s1,  inc_s2,  inc_s3;
  logic mode_edge, inc_edge;

  // Two-flop synchronizers plus a delay flop for rising-edge detection
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      mode_s3 <= 1'b0;
      inc_s1  <= 1'b0;
      inc_s2  <= 1'b0;
      inc_s3  <= 1'b0;
    end else begin
      mode_s1 <= btn_mode;
      mode_s2 <= mode_s1;
      mode_s3 <= mode_s2;
      inc_s1  <= btn_inc;
      inc_s2  <= inc_s1;
      inc_s3  <= inc_s2;
    end
  end

  assign mode_edge = mode_s2 & ~mode_s3;
  assign inc_edge  = inc_s2  & ~inc_s3;
  assign mode      = state;

  // Mode FSM with prescaler, time counters, field editing and blink generation
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      presc     <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      tick_1hz  <= 1'b0;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
    end else begin
      tick_1hz <= 1'b0;
      case (state)
        RUN: begin
          blink     <= 1'b0;
          blink_cnt <= '0;
          if (mode_edge) begin
            state <= SET_HOUR;
            presc <= '0;
          end else if (presc == TICK_MAX) begin
            presc    <= '0;
            tick_1hz <= 1'b1;
            if (seconds == 6'd59) begin
              seconds <= '0;
              if (minutes == 6'd59) begin
                minutes <= '0;
                hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
              end else begin
                minutes <= minutes + 6'd1;
              end
            end else begin
              seconds <= seconds + 6'd1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        SET_HOUR, SET_MIN: begin
          presc <= '0;
          if (mode_edge) begin
            // Each new state restarts blink from its visible phase
            blink     <= 1'b0;
            blink_cnt <= '0;
            if (state == SET_HOUR) begin
              state <= SET_MIN;
            end else begin
              state   <= RUN;
              seconds <= '0;
            end
          end else begin
            if (blink_cnt == BLINK_MAX) begin
              blink_cnt <= '0;
              blink     <= ~blink;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            if (inc_edge) begin
              if (state == SET_HOUR)
                hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
              else
                minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            end
          end
        end

        default: begin
          state     <= RUN;
          presc     <= '0;
          blink     <= 1'b0;
          blink_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;

  logic       clk_100MHz;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;
  logic       tick_1hz;

  int n_checks = 0;
  int n_pass   = 0;

  clock_set_controller #(.TICK_DIV(10), .BLINK_DIV(4)) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .mode       (mode),
    .blink      (blink),
    .tick_1hz   (tick_1hz)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  localparam int OP_INC  = 0;
  localparam int OP_BOTH = 1;
  localparam int OP_HOLD = 2;

  typedef struct {
    int          op;
    int          n;
    int unsigned h;
    int unsigned m;
    int unsigned s;
    int unsigned md;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance n clock edges; returns 1 ns after the last rising edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step(4);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(4);
  endtask

  function automatic logic [31:0] pack(input int unsigned h, input int unsigned m,
                                       input int unsigned s, input int unsigned md);
    logic [31:0] r;
    r = {13'd0, 5'(h), 6'(m), 6'(s), 2'(md)};
    return r;
  endfunction

  initial begin
    int tick_cnt;
    int tick_bad;
    logic [31:0] act;

    vecs[0] = '{op: OP_INC,  n: 25, h: 1,  m: 0,  s: 0, md: 1};
    vecs[1] = '{op: OP_INC,  n: 22, h: 23, m: 0,  s: 0, md: 1};
    vecs[2] = '{op: OP_BOTH, n: 1,  h: 23, m: 0,  s: 0, md: 2};
    vecs[3] = '{op: OP_INC,  n: 61, h: 23, m: 1,  s: 0, md: 2};
    vecs[4] = '{op: OP_INC,  n: 58, h: 23, m: 59, s: 0, md: 2};
    vecs[5] = '{op: OP_HOLD, n: 50, h: 23, m: 0,  s: 0, md: 2};
    vecs[6] = '{op: OP_INC,  n: 59, h: 23, m: 59, s: 0, md: 2};

    rst      = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #1 rst = 1'b1;
    step(3);
    chk("reset_hours",   32'(hours),    32'd0);
    chk("reset_minutes", 32'(minutes),  32'd0);
    chk("reset_seconds", 32'(seconds),  32'd0);
    chk("reset_mode",    32'(mode),     32'd0);
    chk("reset_blink",   32'(blink),    32'd0);
    chk("reset_tick",    32'(tick_1hz), 32'd0);

    // Free run for 35 cycles: ticks expected on cycles 10, 20, 30 only
    rst = 1'b0;
    tick_cnt = 0;
    tick_bad = 0;
    for (int c = 1; c <= 35; c++) begin
      step(1);
      if (tick_1hz) begin
        tick_cnt++;
        if (c % 10 != 0) tick_bad++;
      end
    end
    chk("run35_seconds",   32'(seconds), 32'd3);
    chk("run35_tick_count", 32'(tick_cnt), 32'd3);
    chk("run35_tick_spacing", 32'(tick_bad), 32'd0);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {26'd0, seconds} | 32'(hours) | 32'(minutes) | 32'(mode) | 32'(tick_1hz),
        32'd0);
    @(posedge clk_100MHz);
    #1 rst = 1'b0;

    // Mode press: transition on the third edge after the button is sampled
    btn_mode = 1'b1;
    step(2);
    chk("mode_before_3rd_edge", 32'(mode), 32'd0);
    step(1);
    chk("mode_on_3rd_edge", 32'(mode), 32'd1);
    chk("blink_entry", 32'(blink), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk($sformatf("blink_k%0d", k), 32'(blink), 32'((k / 4) % 2));
    end
    btn_mode = 1'b0;
    step(4);
    chk("set_hour_held_mode", 32'(mode), 32'd1);

    // Table-driven edits in the set states
    for (int v = 0; v < 7; v++) begin
      case (vecs[v].op)
        OP_INC:  for (int p = 0; p < vecs[v].n; p++) press(1'b0, 1'b1);
        OP_BOTH: press(1'b1, 1'b1);
        default: begin
          btn_inc = 1'b1;
          step(vecs[v].n);
          btn_inc = 1'b0;
          step(4);
        end
      endcase
      act = pack(hours, minutes, seconds, mode);
      chk($sformatf("vec%0d", v), act, pack(vecs[v].h, vecs[v].m, vecs[v].s, vecs[v].md));
    end

    // Back to RUN at 23:59:00, first tick exactly 10 cycles later
    btn_mode = 1'b1;
    step(3);
    chk("enter_run_mode",    32'(mode),    32'd0);
    chk("enter_run_seconds", 32'(seconds), 32'd0);
    chk("enter_run_blink",   32'(blink),   32'd0);
    step(9);
    chk("no_tick_at_9", {31'd0, tick_1hz}, 32'd0);
    btn_mode = 1'b0;
    step(1);
    chk("first_tick_at_10", {31'd0, tick_1hz}, 32'd1);
    chk("first_tick_seconds", 32'(seconds), 32'd1);
    step(580);
    chk("pre_rollover", pack(hours, minutes, seconds, mode), pack(23, 59, 59, 0));
    step(9);
    chk("pre_rollover_hold", pack(hours, minutes, seconds, mode), pack(23, 59, 59, 0));
    step(1);
    chk("rollover", pack(hours, minutes, seconds, mode), pack(0, 0, 0, 0));
    chk("rollover_tick", {31'd0, tick_1hz}, 32'd1);

    // Increment presses in RUN change nothing
    press(1'b0, 1'b1);
    chk("run_inc_ignored", pack(hours, minutes, seconds, mode), pack(0, 0, 0, 0));
    chk("run_blink", 32'(blink), 32'd0);
    step(2);
    chk("run_next_tick", {26'd0, seconds} | {31'd0, ~tick_1hz} << 8, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
